// File: rtl/arm_dp_pkg.sv
// Shared constants, FSM state type and opcode helpers for the ARM
// data-processing execute controller.
package arm_dp_pkg;

  // ARM data-processing opcodes
  localparam logic [3:0] ARM_AND = 4'h0;
  localparam logic [3:0] ARM_EOR = 4'h1;
  localparam logic [3:0] ARM_SUB = 4'h2;
  localparam logic [3:0] ARM_RSB = 4'h3;
  localparam logic [3:0] ARM_ADD = 4'h4;
  localparam logic [3:0] ARM_ADC = 4'h5;
  localparam logic [3:0] ARM_SBC = 4'h6;
  localparam logic [3:0] ARM_RSC = 4'h7;
  localparam logic [3:0] ARM_TST = 4'h8;
  localparam logic [3:0] ARM_TEQ = 4'h9;
  localparam logic [3:0] ARM_CMP = 4'hA;
  localparam logic [3:0] ARM_CMN = 4'hB;
  localparam logic [3:0] ARM_ORR = 4'hC;
  localparam logic [3:0] ARM_MOV = 4'hD;
  localparam logic [3:0] ARM_BIC = 4'hE;
  localparam logic [3:0] ARM_MVN = 4'hF;

  // ALU operation encodings
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_BIC = 5'b00001;
  localparam logic [4:0] ALU_ORR = 5'b00010;
  localparam logic [4:0] ALU_EOR = 5'b00011;
  localparam logic [4:0] ALU_ADD = 5'b00100;
  localparam logic [4:0] ALU_ADC = 5'b00101;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SBC = 5'b00111;
  localparam logic [4:0] ALU_RSB = 5'b01000;
  localparam logic [4:0] ALU_RSC = 5'b01001;
  localparam logic [4:0] ALU_MOV = 5'b01010;
  localparam logic [4:0] ALU_MVN = 5'b01011;

  // Condition codes
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  function automatic logic [4:0] map_alu_op(input logic [3:0] opc);
    logic [4:0] op;
    case (opc)
      ARM_AND, ARM_TST: op = ALU_AND;
      ARM_EOR, ARM_TEQ: op = ALU_EOR;
      ARM_SUB, ARM_CMP: op = ALU_SUB;
      ARM_RSB:          op = ALU_RSB;
      ARM_ADD, ARM_CMN: op = ALU_ADD;
      ARM_ADC:          op = ALU_ADC;
      ARM_SBC:          op = ALU_SBC;
      ARM_RSC:          op = ALU_RSC;
      ARM_ORR:          op = ALU_ORR;
      ARM_MOV:          op = ALU_MOV;
      ARM_BIC:          op = ALU_BIC;
      default:          op = ALU_MVN;
    endcase
    return op;
  endfunction

  // Logical ops take C from the shifter and keep V
  function automatic logic is_logical(input logic [3:0] opc);
    return (opc == ARM_AND) || (opc == ARM_EOR) || (opc == ARM_TST) ||
           (opc == ARM_TEQ) || (opc == ARM_ORR) || (opc == ARM_MOV) ||
           (opc == ARM_BIC) || (opc == ARM_MVN);
  endfunction

  // Test-only ops never write the register file but always set flags
  function automatic logic is_test(input logic [3:0] opc);
    return (opc == ARM_TST) || (opc == ARM_TEQ) ||
           (opc == ARM_CMP) || (opc == ARM_CMN);
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_cond_eval.sv
// ARM condition-code evaluator: pass = cond holds for nzcv = {N,Z,C,V}.
module cond_eval
  import arm_dp_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  // Pure decode of the 16 condition encodings
  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: accepts one DP instruction, drives the external
// ALU for one cycle, then retires it (writeback + flag update) in WB.
module alu_exec_ctrl
  import arm_dp_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_cond,
  input  logic [3:0]    req_opcode,
  input  logic          req_s,
  input  logic [RW-1:0] req_rd,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  input  logic          req_shc,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [4:0]    alu_op,
  output logic          alu_cin,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_c,
  input  logic          alu_z,
  input  logic          alu_n,
  input  logic          alu_v,
  output logic          rf_we,
  output logic [RW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [3:0]    cpsr_nzcv,
  output logic          done,
  output logic          skipped
);

  state_e state_q, state_d;

  logic [3:0]    cond_q, opc_q;
  logic          s_q, shc_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] a_q, b_q;

  logic          we_q, done_q, skip_q, upd_q;
  logic [RW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    nzcv_q, nzcv_new_q;

  logic accept, pass;
  logic [3:0] nzcv_calc;

  assign accept = req_valid && req_ready;

  cond_eval u_cond (
    .cond (cond_q),
    .nzcv (nzcv_q),
    .pass (pass)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: EXEC always lasts one cycle; WB can chain straight into EXEC
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = accept ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = accept ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE, ST_WB: req_ready = 1'b1;
      default:        req_ready = 1'b0;
    endcase
  end

  // Request capture on handshake
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cond_q <= '0; opc_q <= '0; s_q <= 1'b0; shc_q <= 1'b0;
      rd_q   <= '0; a_q   <= '0; b_q <= '0;
    end else if (accept) begin
      cond_q <= req_cond; opc_q <= req_opcode; s_q <= req_s; shc_q <= req_shc;
      rd_q   <= req_rd;   a_q   <= req_a;      b_q <= req_b;
    end
  end

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_op  = map_alu_op(opc_q);
  assign alu_cin = nzcv_q[1];

  // Candidate flags: logical ops keep V and take C from the shifter
  always_comb begin
    nzcv_calc = {alu_n, alu_z, alu_c, alu_v};
    if (is_logical(opc_q)) nzcv_calc = {alu_n, alu_z, shc_q, nzcv_q[0]};
  end

  // Retire registers: loaded at the end of EXEC so they are live only in WB
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      we_q <= 1'b0; done_q <= 1'b0; skip_q <= 1'b0; upd_q <= 1'b0;
      waddr_q <= '0; wdata_q <= '0; nzcv_new_q <= '0;
    end else begin
      we_q <= 1'b0; done_q <= 1'b0; skip_q <= 1'b0; upd_q <= 1'b0;
      if (state_q == ST_EXEC) begin
        we_q       <= pass && !is_test(opc_q);
        done_q     <= 1'b1;
        skip_q     <= !pass;
        upd_q      <= pass && (s_q || is_test(opc_q));
        waddr_q    <= rd_q;
        wdata_q    <= alu_out;
        nzcv_new_q <= nzcv_calc;
      end
    end
  end

  // CPSR flags commit at the end of WB, ahead of the next EXEC
  always_ff @(posedge clk) begin
    if (!reset_n)                       nzcv_q <= 4'b0000;
    else if (state_q == ST_WB && upd_q) nzcv_q <= nzcv_new_q;
  end

  assign rf_we     = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign done      = done_q;
  assign skipped   = skip_q;
  assign cpsr_nzcv = nzcv_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl with a behavioural ALU attached.
module tb_alu_exec_ctrl;

  localparam int DW = 32;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready;
  logic [3:0]    req_cond, req_opcode;
  logic          req_s, req_shc;
  logic [RW-1:0] req_rd;
  logic [DW-1:0] req_a, req_b;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic [4:0]    alu_op;
  logic          alu_cin, alu_c, alu_z, alu_n, alu_v;
  logic          rf_we, done, skipped;
  logic [RW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [3:0]    cpsr_nzcv;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cond(req_cond), .req_opcode(req_opcode), .req_s(req_s),
    .req_rd(req_rd), .req_a(req_a), .req_b(req_b), .req_shc(req_shc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cpsr_nzcv(cpsr_nzcv), .done(done), .skipped(skipped)
  );

  // Behavioural ALU: x + y + ci with ARM carry/overflow semantics
  logic [DW:0]   sum;
  logic [DW-1:0] x, y;
  logic          ci, arith;
  always_comb begin
    x = alu_a; y = alu_b; ci = 1'b0; arith = 1'b1;
    alu_out = '0;
    case (alu_op)
      5'b00100: begin x = alu_a; y = alu_b;  ci = 1'b0;    end
      5'b00101: begin x = alu_a; y = alu_b;  ci = alu_cin; end
      5'b00110: begin x = alu_a; y = ~alu_b; ci = 1'b1;    end
      5'b00111: begin x = alu_a; y = ~alu_b; ci = alu_cin; end
      5'b01000: begin x = alu_b; y = ~alu_a; ci = 1'b1;    end
      5'b01001: begin x = alu_b; y = ~alu_a; ci = alu_cin; end
      default:  arith = 1'b0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{DW{1'b0}}, ci};
    if (arith) alu_out = sum[DW-1:0];
    else case (alu_op)
      5'b00000: alu_out = alu_a & alu_b;
      5'b00001: alu_out = alu_a & ~alu_b;
      5'b00010: alu_out = alu_a | alu_b;
      5'b00011: alu_out = alu_a ^ alu_b;
      5'b01010: alu_out = alu_b;
      default:  alu_out = ~alu_b;
    endcase
    alu_n = alu_out[DW-1];
    alu_z = (alu_out == '0);
    alu_c = arith ? sum[DW] : 1'b0;
    alu_v = arith ? ((x[DW-1] == y[DW-1]) && (sum[DW-1] != x[DW-1])) : 1'b0;
  end

  typedef struct {
    logic          we;
    logic [RW-1:0] wa;
    logic [DW-1:0] wd;
    logic          skip;
    logic [3:0]    nz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop one expectation per retired instruction; flags are
  // checked on the following cycle, after the WB commit edge
  initial begin : monitor
    exp_t e;
    logic [3:0] nz_exp;
    logic nz_pend;
    nz_pend = 1'b0;
    nz_exp  = '0;
    forever begin
      @(negedge clk);
      if (nz_pend) begin
        chk("cpsr_after_wb", {28'd0, cpsr_nzcv}, {28'd0, nz_exp});
        nz_pend = 1'b0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no retirement");
        end else begin
          e = sb.pop_front();
          chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
          chk("skipped", {31'd0, skipped}, {31'd0, e.skip});
          if (e.we) begin
            chk("rf_waddr", {28'd0, rf_waddr}, {28'd0, e.wa});
            chk("rf_wdata", rf_wdata, e.wd);
          end
          nz_exp  = e.nz;
          nz_pend = 1'b1;
        end
      end else if (rf_we) begin
        checks++; errors++;
        $display("FAIL rf_we_without_done: got rf_we=1 expected 0");
      end
    end
  end

  task automatic issue(input logic [3:0] c, input logic [3:0] o, input logic s,
                       input logic [RW-1:0] rd, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic shc,
                       input logic push, input exp_t e);
    int n;
    if (push) sb.push_back(e);
    req_cond = c; req_opcode = o; req_s = s; req_rd = rd;
    req_a = a; req_b = b; req_shc = shc; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: got req_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    reset_n = 1'b0; req_valid = 1'b0;
    req_cond = '0; req_opcode = '0; req_s = 1'b0; req_rd = '0;
    req_a = '0; req_b = '0; req_shc = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_nzcv",  {28'd0, cpsr_nzcv}, 32'd0);
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_done",  {31'd0, done}, 32'd0);
    reset_n = 1'b1;

    // ADD AL S: FFFFFFFF+1 -> 0, Z and C set
    e = '{1'b1, 4'd3, 32'h0, 1'b0, 4'b0110};
    issue(4'hE, 4'h4, 1'b1, 4'd3, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, e);
    drain();
    // ADD AL S: signed overflow -> N,V
    e = '{1'b1, 4'd4, 32'h8000_0000, 1'b0, 4'b1001};
    issue(4'hE, 4'h4, 1'b1, 4'd4, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, e);
    drain();
    // MOV S, B=0, shc=1: Z=1, C=1, V kept at 1
    e = '{1'b1, 4'd2, 32'h0, 1'b0, 4'b0111};
    issue(4'hE, 4'hD, 1'b1, 4'd2, 32'h1234, 32'h0, 1'b1, 1'b1, e);
    drain();
    // SUB S: 0-2 -> FFFFFFFE, N only
    e = '{1'b1, 4'd6, 32'hFFFF_FFFE, 1'b0, 4'b1000};
    issue(4'hE, 4'h2, 1'b1, 4'd6, 32'h0, 32'h2, 1'b0, 1'b1, e);
    drain();
    // CMP S=0 forces flag update; then ADDEQ and ADDNE back-to-back
    e = '{1'b0, 4'd0, 32'h0, 1'b0, 4'b0110};
    issue(4'hE, 4'hA, 1'b0, 4'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, e);
    e = '{1'b1, 4'd1, 32'h7, 1'b0, 4'b0110};
    issue(4'h0, 4'h4, 1'b0, 4'd1, 32'h5, 32'h2, 1'b0, 1'b1, e);
    e = '{1'b0, 4'd7, 32'h0, 1'b1, 4'b0110};
    issue(4'h1, 4'h4, 1'b1, 4'd7, 32'h5, 32'h2, 1'b0, 1'b1, e);
    // cond 1111 never executes, even with S=1
    e = '{1'b0, 4'd8, 32'h0, 1'b1, 4'b0110};
    issue(4'hF, 4'h4, 1'b1, 4'd8, 32'h1, 32'h1, 1'b0, 1'b1, e);
    drain();
    // ADC S uses carry-in C=1: 1+1+1 = 3, flags clear
    e = '{1'b1, 4'd9, 32'h3, 1'b0, 4'b0000};
    issue(4'hE, 4'h5, 1'b1, 4'd9, 32'h1, 32'h1, 1'b0, 1'b1, e);
    drain();
    // TST S=0: Z=1, C from shifter, V kept, no write
    e = '{1'b0, 4'd0, 32'h0, 1'b0, 4'b0110};
    issue(4'hE, 4'h8, 1'b0, 4'd0, 32'hF0, 32'h0F, 1'b1, 1'b1, e);
    // EOR S=0: writes, flags unchanged
    e = '{1'b1, 4'd10, 32'hF0, 1'b0, 4'b0110};
    issue(4'hE, 4'h1, 1'b0, 4'd10, 32'hFF, 32'h0F, 1'b0, 1'b1, e);
    // RSB S: 5-1 = 4, carry (no borrow)
    e = '{1'b1, 4'd11, 32'h4, 1'b0, 4'b0010};
    issue(4'hE, 4'h3, 1'b1, 4'd11, 32'h1, 32'h5, 1'b0, 1'b1, e);
    drain();

    // Reset during EXEC: aborts without retirement and clears flags
    e = '{1'b0, 4'd0, 32'h0, 1'b0, 4'b0000};
    issue(4'hE, 4'h4, 1'b1, 4'd12, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, e);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_rf_we", {31'd0, rf_we}, 32'd0);
    chk("abort_done",  {31'd0, done}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_nzcv",  {28'd0, cpsr_nzcv}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Recovery after abort
    e = '{1'b1, 4'd5, 32'h5, 1'b0, 4'b0000};
    issue(4'hE, 4'h4, 1'b1, 4'd5, 32'h2, 32'h3, 1'b0, 1'b1, e);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
